// File: rtl/uart_tx_queue.sv
// Byte FIFO plus transmit sequencer that feeds the UART transmitter one byte per TxDone.
// Optional TxDone watchdog is compiled in when TXQ_WDOG_EN is defined.
module uart_tx_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic [7:0]    wrData_i,
  input  logic          wrEn_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o,
  output logic          busy_o,
  output logic [7:0]    txData_o,
  output logic          txEn_o,
  input  logic          txDone_i,
  output logic          wdogErr_o
);

  // One timer serves both GAP and the SEND watchdog; the two states never overlap.
  localparam int unsigned MaxWait = (GAP_CYCLES > WDOG_CYCLES) ? GAP_CYCLES : WDOG_CYCLES;
  localparam int unsigned TmW     = (MaxWait < 2) ? 1 : $clog2(MaxWait);
  localparam logic [TmW-1:0] GapLast  = TmW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW:0]    DepthCnt = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_e;

  state_e         state_q, state_d;
  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]    count_q, count_d;
  logic           full_q, full_d, empty_q, empty_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     txData_q, txData_d;
  logic           txEn_q, txEn_d;
  logic           txDone_q;
  logic [TmW-1:0] timer_q, timer_d;
  logic           doneRise, wrAccept, pop, wdogExpire;

  assign wrAccept = wrEn_i & ~full_q & ~clear_i;
  assign pop      = (state_q == LOAD) & ~clear_i;
  assign doneRise = txDone_i & ~txDone_q;

`ifdef TXQ_WDOG_EN
  localparam logic [TmW-1:0] WdogLast = TmW'(WDOG_CYCLES - 1);
  logic wdogErr_q;

  assign wdogExpire = (state_q == SEND) & ~doneRise & (timer_q == WdogLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         wdogErr_q <= 1'b0;
    else if (clear_i)    wdogErr_q <= 1'b0;
    else if (wdogExpire) wdogErr_q <= 1'b1;
  end

  assign wdogErr_o = wdogErr_q;
`else
  assign wdogExpire = 1'b0;
  assign wdogErr_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // IDLE also looks at the write being accepted now, so a lone byte sees TxEn two cycles after WrEn.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty_q || wrAccept) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND: begin
        if (doneRise)        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        else if (wdogExpire) state_d = IDLE;
      end
      GAP:     if (timer_q == GapLast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
    timer_d = (state_d != state_q) ? '0 : timer_q + TmW'(1);
  end

  always_comb begin
    busy_o = (state_q != IDLE);
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    txData_d   = txData_q;
    txEn_d     = pop;
    if (wrAccept) wrPtr_d = wrPtr_q + AW'(1);
    if (pop) begin
      rdPtr_d  = rdPtr_q + AW'(1);
      txData_d = mem_q[rdPtr_q];
    end
    if (wrAccept && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (!wrAccept && pop) count_d = count_q - (AW + 1)'(1);
    if (wrEn_i && full_q) overflow_d = 1'b1;
    if (clear_i) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      txEn_d     = 1'b0;
    end
    full_d  = (count_d == DepthCnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      txData_q   <= 8'h00;
      txEn_q     <= 1'b0;
      txDone_q   <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      txData_q   <= txData_d;
      txEn_q     <= txEn_d;
      txDone_q   <= txDone_i;
    end
  end

  // Storage carries no reset; stale contents are never read past the pointers.
  always_ff @(posedge clk_i) begin
    if (wrAccept) mem_q[wrPtr_q] <= wrData_i;
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign txData_o   = txData_q;
  assign txEn_o     = txEn_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: latency, ordering, overflow, clear and (with TXQ_WDOG_EN) the watchdog.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] wrData = 8'h00;
  logic       wrEn = 1'b0;
  logic       txDone = 1'b0;
  logic       full, empty, overflow, busy, txEn, wdogErr;
  logic [4:0] count;
  logic [7:0] txData;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int gotCyc[$];
  int doneCyc[$];

  uart_tx_queue #(.DEPTH(16), .AW(4), .GAP_CYCLES(0), .WDOG_CYCLES(100)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .wrData_i(wrData), .wrEn_i(wrEn),
    .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(overflow), .busy_o(busy),
    .txData_o(txData), .txEn_o(txEn), .txDone_i(txDone), .wdogErr_o(wdogErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Every TxEn pulse is logged with the cycle it became visible.
  always @(negedge clk) begin
    if (rst_n && txEn) begin
      got.push_back(txData);
      gotCyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] gotAt(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  function automatic int cycAt(input int i);
    if (i < gotCyc.size()) return gotCyc[i];
    return -1000;
  endfunction

  task automatic flushLog();
    got.delete();
    gotCyc.delete();
    doneCyc.delete();
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  // Answers byte k (1-based) with a one-cycle TxDone, delay cycles after its TxEn is seen.
  task automatic serveBytes(input int first, input int total, input int delay);
    int w;
    for (int k = first; k <= total; k++) begin
      w = 0;
      while (got.size() < k && w < 300) begin
        step(1);
        w++;
      end
      if (got.size() < k) begin
        compared++; mismatched++;
        $display("[TB] FAIL serve_timeout: got %0d pulses, required %0d", got.size(), k);
        return;
      end
      step(delay);
      txDone = 1'b1;
      doneCyc.push_back(cyc);
      step(1);
      txDone = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    compared++; if (txData !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_txData: got %h required 00", txData); end
    compared++; if (txEn !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_txEn: got %b required 0", txEn); end
    compared++; if (full !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_full: got %b required 0", full); end
    compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_empty: got %b required 1", empty); end
    compared++; if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL rst_count: got %0d required 0", count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_overflow: got %b required 0", overflow); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
    compared++; if (wdogErr !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_wdogErr: got %b required 0", wdogErr); end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single();
    int wc;
    flushLog();
    wrData = 8'h55; wrEn = 1'b1; wc = cyc;
    step(1);
    wrEn = 1'b0;
    compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL single_empty: got %b required 0", empty); end
    compared++; if (count !== 5'd1) begin mismatched++; $display("[TB] FAIL single_count1: got %0d required 1", count); end
    step(1);
    compared++; if (txEn !== 1'b1) begin mismatched++; $display("[TB] FAIL single_txEn: got %b required 1", txEn); end
    compared++; if (txData !== 8'h55) begin mismatched++; $display("[TB] FAIL single_txData: got %h required 55", txData); end
    compared++; if (count !== 5'd0) begin mismatched++; $display("[TB] FAIL single_count0: got %0d required 0", count); end
    compared++; if (cycAt(0) - wc !== 2) begin mismatched++; $display("[TB] FAIL single_latency: got %0d required 2", cycAt(0) - wc); end
    step(1);
    compared++; if (txEn !== 1'b0) begin mismatched++; $display("[TB] FAIL single_txEnPulse: got %b required 0", txEn); end
    step(5);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy: got %b required 1", busy); end
    txDone = 1'b1;
    step(1);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_idle: got %b required 0", busy); end
    compared++; if (txData !== 8'h55) begin mismatched++; $display("[TB] FAIL single_hold: got %h required 55", txData); end
    txDone = 1'b0;
    step(2);
  endtask

  task automatic test_back_to_back();
    flushLog();
    for (int i = 1; i <= 3; i++) begin
      wrData = 8'(i); wrEn = 1'b1;
      step(1);
    end
    wrEn = 1'b0;
    serveBytes(1, 3, 10);
    step(5);
    compared++; if (got.size() !== 3) begin mismatched++; $display("[TB] FAIL b2b_pulses: got %0d required 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (gotAt(i) !== 8'(i + 1)) begin mismatched++; $display("[TB] FAIL b2b_data%0d: got %h required %h", i, gotAt(i), 8'(i + 1)); end
    end
    compared++; if (cycAt(1) - doneCyc[0] !== 3) begin mismatched++; $display("[TB] FAIL b2b_lat1: got %0d required 3", cycAt(1) - doneCyc[0]); end
    compared++; if (cycAt(2) - doneCyc[1] !== 3) begin mismatched++; $display("[TB] FAIL b2b_lat2: got %0d required 3", cycAt(2) - doneCyc[1]); end
    compared++; if (busy !== 1'b0 || empty !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_end: got busy=%b empty=%b required busy=0 empty=1", busy, empty); end
  endtask

  task automatic test_overflow();
    int bad;
    flushLog();
    for (int i = 0; i < 18; i++) begin
      wrData = 8'h10 + 8'(i); wrEn = 1'b1;
      step(1);
    end
    wrEn = 1'b0;
    compared++; if (count !== 5'd16) begin mismatched++; $display("[TB] FAIL ovf_count: got %0d required 16", count); end
    compared++; if (full !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_full: got %b required 1", full); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_flag: got %b required 1", overflow); end
    compared++; if (got.size() !== 1) begin mismatched++; $display("[TB] FAIL ovf_inflight: got %0d required 1", got.size()); end
    serveBytes(1, 17, 10);
    step(5);
    compared++; if (got.size() !== 17) begin mismatched++; $display("[TB] FAIL ovf_sent: got %0d required 17", got.size()); end
    bad = -1;
    for (int i = 0; i < 17; i++) if (bad < 0 && gotAt(i) !== 8'h10 + 8'(i)) bad = i;
    compared++; if (bad >= 0) begin mismatched++; $display("[TB] FAIL ovf_order: byte %0d got %h required %h", bad, gotAt(bad), 8'h10 + 8'(bad)); end
    compared++; if (overflow !== 1'b1 || empty !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_end: got overflow=%b empty=%b required 1 1", overflow, empty); end
  endtask

  task automatic test_full_pop();
    int bad;
    pulseClear();
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL fp_clearOvf: got %b required 0", overflow); end
    flushLog();
    for (int i = 0; i < 17; i++) begin
      wrData = 8'h40 + 8'(i); wrEn = 1'b1;
      step(1);
    end
    wrEn = 1'b0;
    step(2);
    txDone = 1'b1;
    step(1);
    txDone = 1'b0;
    step(1);
    compared++; if (full !== 1'b1 || count !== 5'd16) begin mismatched++; $display("[TB] FAIL fp_preload: got full=%b count=%0d required 1 16", full, count); end
    wrData = 8'h99; wrEn = 1'b1;
    step(1);
    wrEn = 1'b0;
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL fp_ovf: got %b required 1", overflow); end
    compared++; if (count !== 5'd15) begin mismatched++; $display("[TB] FAIL fp_count: got %0d required 15", count); end
    compared++; if (full !== 1'b0) begin mismatched++; $display("[TB] FAIL fp_full: got %b required 0", full); end
    compared++; if (txEn !== 1'b1 || txData !== 8'h41) begin mismatched++; $display("[TB] FAIL fp_pop: got txEn=%b data=%h required 1 41", txEn, txData); end
    serveBytes(2, 17, 10);
    step(5);
    compared++; if (got.size() !== 17) begin mismatched++; $display("[TB] FAIL fp_sent: got %0d required 17", got.size()); end
    bad = -1;
    for (int i = 0; i < 17; i++) if (bad < 0 && gotAt(i) !== 8'h40 + 8'(i)) bad = i;
    compared++; if (bad >= 0) begin mismatched++; $display("[TB] FAIL fp_order: byte %0d got %h required %h", bad, gotAt(bad), 8'h40 + 8'(bad)); end
  endtask

  task automatic test_clear();
    flushLog();
    for (int i = 0; i < 6; i++) begin
      wrData = 8'h60 + 8'(i); wrEn = 1'b1;
      step(1);
    end
    wrEn = 1'b0;
    step(3);
    compared++; if (count !== 5'd5) begin mismatched++; $display("[TB] FAIL clr_pre: got %0d required 5", count); end
    clear = 1'b1; wrData = 8'hEE; wrEn = 1'b1;
    step(1);
    clear = 1'b0; wrEn = 1'b0;
    compared++; if (empty !== 1'b1 || count !== 5'd0) begin mismatched++; $display("[TB] FAIL clr_fifo: got empty=%b count=%0d required 1 0", empty, count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_ovf: got %b required 0", overflow); end
    compared++; if (busy !== 1'b0 || full !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_state: got busy=%b full=%b required 0 0", busy, full); end
    step(10);
    txDone = 1'b1;
    step(2);
    txDone = 1'b0;
    step(20);
    compared++; if (got.size() !== 1) begin mismatched++; $display("[TB] FAIL clr_noTx: got %0d pulses required 1", got.size()); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_stale: got busy=%b required 0", busy); end
  endtask

  task automatic test_watchdog();
`ifdef TXQ_WDOG_EN
    int t0;
    int w;
    flushLog();
    wrData = 8'h77; wrEn = 1'b1;
    step(1);
    wrData = 8'h78;
    step(1);
    wrEn = 1'b0;
    t0 = cycAt(0);
    w = 0;
    while (cyc < t0 + 99 && w < 300) begin
      step(1);
      w++;
    end
    compared++; if (wdogErr !== 1'b0) begin mismatched++; $display("[TB] FAIL wd_early: got %b required 0", wdogErr); end
    step(1);
    compared++; if (wdogErr !== 1'b1) begin mismatched++; $display("[TB] FAIL wd_expire: got %b required 1", wdogErr); end
    step(2);
    compared++; if (gotAt(1) !== 8'h78) begin mismatched++; $display("[TB] FAIL wd_next: got %h required 78", gotAt(1)); end
    compared++; if (cycAt(1) - t0 !== 102) begin mismatched++; $display("[TB] FAIL wd_nextLat: got %0d required 102", cycAt(1) - t0); end
    pulseClear();
    compared++; if (wdogErr !== 1'b0) begin mismatched++; $display("[TB] FAIL wd_clear: got %b required 0", wdogErr); end
`else
    flushLog();
    wrData = 8'h77; wrEn = 1'b1;
    step(1);
    wrEn = 1'b0;
    step(150);
    compared++; if (wdogErr !== 1'b0) begin mismatched++; $display("[TB] FAIL wd_tied: got %b required 0", wdogErr); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL wd_wait: got busy=%b required 1", busy); end
    compared++; if (got.size() !== 1) begin mismatched++; $display("[TB] FAIL wd_pulses: got %0d required 1", got.size()); end
    pulseClear();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_clear();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
